// File: rtl/tl_mem_responder_if.sv
// Request/response bundle between an initiator and tl_mem_responder.
// Signal suffixes are from the responder's point of view.
interface tl_mem_if;
  logic [2:0]  a_opcode_i;
  logic [11:0] a_address_i;
  logic [31:0] a_data_i;
  logic        a_ready_i;
  logic        a_accept_o;
  logic        d_ready_o;
  logic [2:0]  d_opcode_o;
  logic [31:0] d_data_o;
  logic        d_error_o;

  modport master (
    output a_opcode_i, a_address_i, a_data_i, a_ready_i,
    input  a_accept_o, d_ready_o, d_opcode_o, d_data_o, d_error_o
  );

  modport slave (
    input  a_opcode_i, a_address_i, a_data_i, a_ready_i,
    output a_accept_o, d_ready_o, d_opcode_o, d_data_o, d_error_o
  );
endinterface

// File: rtl/tl_mem_responder.sv
// Single-outstanding word memory responder: Get/PutFullData requests with a
// programmable response delay of LATENCY+1 cycles after the accept edge.
module tl_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 0
) (
  input  logic       clk,
  input  logic       reset,
  tl_mem_if.slave    bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [2:0] OP_GET      = 3'b100;
  localparam logic [2:0] OP_PUT      = 3'b000;
  localparam logic [2:0] OP_ACK_DATA = 3'b001;
  localparam logic [2:0] OP_ACK      = 3'b000;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [11:0] address;
    logic [31:0] data;
  } req_t;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  req_t        req_q, req_d;
  logic        d_ready_q, d_ready_d;
  logic [2:0]  d_opcode_q, d_opcode_d;
  logic [31:0] d_data_q, d_data_d;
  logic        d_error_q, d_error_d;

  logic [31:0] mem [DEPTH];

  logic        accept;
  logic        enter_resp;
  logic        err;
  logic        is_get;
  logic        do_write;
  req_t        cur;
  logic [9:0]  word;
  logic [AW-1:0] idx;

  assign accept = reset && bus.a_ready_i && (state_q == IDLE || state_q == RESP);

  // The access happens on the edge entering RESP; with LATENCY=0 that is the
  // accept edge itself, so the live A inputs are used instead of req_q.
  always_comb begin
    cur    = accept ? {bus.a_opcode_i, bus.a_address_i, bus.a_data_i} : req_q;
    word   = cur.address[11:2];
    err    = (cur.address[1:0] != 2'b00) || (32'(word) >= 32'(DEPTH)) ||
             (cur.opcode != OP_GET && cur.opcode != OP_PUT);
    is_get = !err && cur.opcode == OP_GET;
    idx    = AW'(word);
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    enter_resp = 1'b0;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          req_d = cur;
          if (LATENCY == 0) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = WAIT;
            cnt_d   = 3'(LATENCY);
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d    = RESP;
          enter_resp = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    d_ready_d  = enter_resp;
    d_opcode_d = d_opcode_q;
    d_data_d   = d_data_q;
    d_error_d  = d_error_q;
    if (enter_resp) begin
      d_error_d  = err;
      d_opcode_d = is_get ? OP_ACK_DATA : OP_ACK;
      d_data_d   = is_get ? mem[idx] : 32'd0;
    end
    do_write = enter_resp && !err && cur.opcode == OP_PUT;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= 3'd0;
      req_q      <= '0;
      d_ready_q  <= 1'b0;
      d_opcode_q <= 3'd0;
      d_data_q   <= 32'd0;
      d_error_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_q      <= req_d;
      d_ready_q  <= d_ready_d;
      d_opcode_q <= d_opcode_d;
      d_data_q   <= d_data_d;
      d_error_q  <= d_error_d;
    end
  end

  // Memory survives reset; only the write itself is suppressed.
  always_ff @(posedge clk) begin
    if (reset && do_write) mem[idx] <= cur.data;
  end

  assign bus.a_accept_o = accept;
  assign bus.d_ready_o  = d_ready_q;
  assign bus.d_opcode_o = d_opcode_q;
  assign bus.d_data_o   = d_data_q;
  assign bus.d_error_o  = d_error_q;
endmodule

// File: doc/tl_mem_responder.md
TL_MEM_RESPONDER -- requirements
Module: tl_mem_responder

Interface
REQ-001: Parameter DEPTH, default 1024, is the number of 32-bit memory words.
REQ-002: Parameter LATENCY, default 0, range 0..7, is the number of extra wait cycles between request capture and response.
REQ-003: clk  input  1  is the single clock; all state updates on the rising edge.
REQ-004: reset  input  1  is the synchronous, active-low reset: 0 = reset asserted, 1 = run.
REQ-005: a_opcode_i  input  3  is the request opcode: 3'b100 = Get, 3'b000 = PutFullData.
REQ-006: a_address_i  input  12  is the byte address.
REQ-007: a_data_i  input  32  is the Put write data.
REQ-008: a_ready_i  input  1  is the request-valid strobe from the initiator.
REQ-009: a_accept_o  output  1  indicates the request on the A inputs is captured on this clock edge.
REQ-010: d_ready_o  output  1  is the response-valid strobe.
REQ-011: d_opcode_o  output  3  is the response opcode: 3'b001 = AccessAckData, 3'b000 = AccessAck.
REQ-012: d_data_o  output  32  is the read data.
REQ-013: d_error_o  output  1  is the response error flag.

Function
REQ-014: The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015: a_accept_o SHALL be combinationally 1 exactly when the state is IDLE or RESP and a_ready_i=1.
REQ-016: On an accepting edge, opcode, address and data SHALL be captured into a one-entry request register.
REQ-017: After acceptance, the next state SHALL be RESP if LATENCY=0, otherwise WAIT with the wait counter loaded to LATENCY.
REQ-018: In WAIT, the counter SHALL decrement each cycle; the block SHALL move to RESP on the edge where the counter equals 1, and a_ready_i SHALL be ignored.
REQ-019: In RESP, d_ready_o SHALL be 1 for exactly one cycle.
REQ-020: From RESP, the next state SHALL follow REQ-017 if a new request is accepted that cycle, else IDLE; back-to-back throughput is one response per (LATENCY+1) cycles.
REQ-021: The memory access SHALL occur on the edge entering RESP: a Get registers mem[address[11:2]] into d_data_o; a Put writes a_data into mem[address[11:2]].
REQ-022: Response latency SHALL be LATENCY+1 cycles from the accept edge to d_ready_o=1.
REQ-023: A Get response SHALL have d_opcode_o=3'b001; a Put response SHALL have d_opcode_o=3'b000 and d_data_o=0.
REQ-024: Error conditions are address[1:0]!=0, address[11:2]>=DEPTH, or an opcode other than 000/100.
REQ-025: On any error condition, the response SHALL have d_error_o=1, d_data_o=0, and d_opcode_o=3'b000, and no memory write SHALL occur.
REQ-026: When d_ready_o=0, d_opcode_o, d_data_o and d_error_o SHALL hold their last values; the initiator SHALL sample them only while d_ready_o=1.
REQ-027: For a Put followed back-to-back by a Get to the same word, the Get SHALL return the newly written data.
REQ-028: The address index SHALL use address[11:2] truncated to clog2(DEPTH) bits only after the range check passes; there is no wrap-around aliasing.

Reset
REQ-029: When reset=0 at a rising edge, state SHALL go to IDLE, the counter SHALL clear, and d_ready_o, d_opcode_o, d_data_o and d_error_o SHALL become 0.
REQ-030: While reset=0, a_accept_o SHALL be 0.
REQ-031: Reset asserted mid-operation (WAIT or RESP) SHALL drop the pending request, and no response SHALL be issued for it.
REQ-032: Memory contents SHALL NOT be cleared by reset; a Put whose write edge coincides with reset=0 SHALL NOT write.

Verification
REQ-033: Scenario 1, LATENCY=0: Put addr 0x010 data 0xDEADBEEF, then Get 0x010 -> AccessAck (d_opcode_o=000, d_error_o=0), then d_ready_o=1, d_opcode_o=001, d_data_o=0xDEADBEEF.
REQ-034: Scenario 2, LATENCY=3: Get accepted at cycle N -> d_ready_o=1 only at cycle N+4; a_accept_o=0 during cycles N+1..N+3 even with a_ready_i=1.
REQ-035: Scenario 3, misaligned Get 0x013 -> d_error_o=1, d_data_o=0, d_opcode_o=000; a following Put 0x011 leaves mem[4] unchanged.
REQ-036: Scenario 4, opcode 3'b010 -> d_error_o=1, with no write; with DEPTH=256, Get 0x400 -> d_error_o=1.
REQ-037: Scenario 5, LATENCY=2: reset=0 asserted one cycle after accepting a Put 0x020/0x12345678 -> no d_ready_o pulse, and a later Get 0x020 returns the prior contents.
REQ-038: Scenario 6, LATENCY=0: a_ready_i held high for 8 Gets 0x000..0x01C -> 8 consecutive d_ready_o pulses, each with the correct word, and no gaps.
